// File: rtl/uart_frame_sequencer_if.sv
// Byte-wide link between the frame sequencer and the UART transmitter core.
interface uart_frame_sequencer_if;
  logic [7:0] tx_byte;
  logic       tx_start;
  logic       uart_ready;
  logic       uart_done;

  modport master (
    output tx_byte,
    output tx_start,
    input  uart_ready,
    input  uart_done
  );

  modport slave (
    input  tx_byte,
    input  tx_start,
    output uart_ready,
    output uart_done
  );
endinterface

// File: rtl/uart_frame_sequencer.sv
// Turns one arbiter record into a 6-byte UART frame:
// SYNC, address, mode, data_hi, data_lo, XOR checksum.
module uart_frame_sequencer #(
  parameter logic [7:0]  SYNC_BYTE  = 8'hA5,
  parameter int unsigned GAP_CYCLES = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          data_ready,
  input  logic [7:0]                    toPC_address,
  input  logic [7:0]                    toPC_mode,
  input  logic [15:0]                   toPC_data,
  output logic                          tx_complete,
  uart_frame_sequencer_if.master        uart,
  output logic [7:0]                    frame_count,
  output logic                          overrun_err
);

  localparam int GW = 16;
  localparam logic [GW-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;
  localparam logic [2:0]    LAST_IDX = 3'd5;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_DONE,
    GAP
  } state_t;

  state_t        state, state_nxt;
  logic [2:0]    idx, idx_nxt;
  logic [GW-1:0] gap_cnt, gap_nxt;
  logic [7:0]    frame_count_nxt;
  logic          overrun_nxt;
  logic          latch;

  logic [7:0]    addr_q, mode_q, dhi_q, dlo_q, csum_q;

  // Combinational so the arbiter sees busy in the same cycle it raises data_ready.
  assign tx_complete = (state == IDLE) && !data_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      idx         <= '0;
      gap_cnt     <= '0;
      frame_count <= '0;
      overrun_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      idx         <= idx_nxt;
      gap_cnt     <= gap_nxt;
      frame_count <= frame_count_nxt;
      overrun_err <= overrun_nxt;
    end
  end

  // Record fields are only consumed outside IDLE, after a latch, so they carry no reset.
  always_ff @(posedge clk) begin
    if (latch) begin
      addr_q <= toPC_address;
      mode_q <= toPC_mode;
      dhi_q  <= toPC_data[15:8];
      dlo_q  <= toPC_data[7:0];
      csum_q <= toPC_address ^ toPC_mode ^ toPC_data[15:8] ^ toPC_data[7:0];
    end
  end

  always_comb begin
    state_nxt       = state;
    idx_nxt         = idx;
    gap_nxt         = gap_cnt;
    frame_count_nxt = frame_count;
    overrun_nxt     = overrun_err | (data_ready && (state != IDLE));
    latch           = 1'b0;
    uart.tx_start   = 1'b0;

    case (state)
      IDLE: begin
        if (data_ready) begin
          latch     = 1'b1;
          idx_nxt   = '0;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (uart.uart_ready) begin
          uart.tx_start = 1'b1;
          state_nxt     = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (uart.uart_done) begin
          if (idx == LAST_IDX) begin
            frame_count_nxt = frame_count + 8'd1;
            state_nxt       = IDLE;
          end else if (GAP_CYCLES == 0) begin
            idx_nxt   = idx + 3'd1;
            state_nxt = ISSUE;
          end else begin
            gap_nxt   = GAP_LOAD;
            state_nxt = GAP;
          end
        end
      end
      GAP: begin
        if (gap_cnt == '0) begin
          idx_nxt   = idx + 3'd1;
          state_nxt = ISSUE;
        end else begin
          gap_nxt = gap_cnt - 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    uart.tx_byte = '0;
    if (state != IDLE) begin
      case (idx)
        3'd0:    uart.tx_byte = SYNC_BYTE;
        3'd1:    uart.tx_byte = addr_q;
        3'd2:    uart.tx_byte = mode_q;
        3'd3:    uart.tx_byte = dhi_q;
        3'd4:    uart.tx_byte = dlo_q;
        default: uart.tx_byte = csum_q;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_frame_sequencer.sv
// Directed bench: two sequencers (back-to-back and 3-cycle gap) driven by simple UART models.
module tb_uart_frame_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        dr0, dr1;
  logic [7:0]  addr, mode;
  logic [15:0] data;
  logic        tc0, tc1, ov0, ov1;
  logic [7:0]  fc0, fc1;
  logic        rdy0, rdy1, dn0, dn1;
  int          cnt0, cnt1;

  uart_frame_sequencer_if u0();
  uart_frame_sequencer_if u1();
  assign u0.uart_ready = rdy0;
  assign u0.uart_done  = dn0;
  assign u1.uart_ready = rdy1;
  assign u1.uart_done  = dn1;

  uart_frame_sequencer #(.SYNC_BYTE(8'hA5), .GAP_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .data_ready(dr0), .toPC_address(addr), .toPC_mode(mode),
    .toPC_data(data), .tx_complete(tc0), .uart(u0), .frame_count(fc0), .overrun_err(ov0));

  uart_frame_sequencer #(.SYNC_BYTE(8'hA5), .GAP_CYCLES(3)) dut1 (
    .clk(clk), .reset(reset), .data_ready(dr1), .toPC_address(addr), .toPC_mode(mode),
    .toPC_data(data), .tx_complete(tc1), .uart(u1), .frame_count(fc1), .overrun_err(ov1));

  // UART models: uart_done pulses about 10 cycles after each tx_start
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt0 <= 0; dn0 <= 1'b0;
    end else begin
      dn0 <= (cnt0 == 1);
      if (u0.tx_start) cnt0 <= 10;
      else if (cnt0 != 0) cnt0 <= cnt0 - 1;
    end
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt1 <= 0; dn1 <= 1'b0;
    end else begin
      dn1 <= (cnt1 == 1);
      if (u1.tx_start) cnt1 <= 10;
      else if (cnt1 != 0) cnt1 <= cnt1 - 1;
    end
  end

  // Capture every started byte and the idle cycles since the preceding uart_done
  int         ns0 = 0, ns1 = 0, gapc0 = 0, gapc1 = 0, bad0 = 0, bad1 = 0;
  logic       ps0 = 1'b0, ps1 = 1'b0;
  logic [7:0] cap0 [0:2047];
  logic [7:0] cap1 [0:2047];
  int         gap0 [0:2047];
  int         gap1 [0:2047];

  always @(posedge clk) begin
    ps0 <= u0.tx_start;
    if (u0.tx_start && (ps0 || tc0)) bad0 <= bad0 + 1;
    if (u0.tx_start) begin
      cap0[ns0 % 2048] <= u0.tx_byte;
      gap0[ns0 % 2048] <= gapc0;
      ns0   <= ns0 + 1;
      gapc0 <= 0;
    end else if (dn0) gapc0 <= 0;
    else gapc0 <= gapc0 + 1;
  end

  always @(posedge clk) begin
    ps1 <= u1.tx_start;
    if (u1.tx_start && (ps1 || tc1)) bad1 <= bad1 + 1;
    if (u1.tx_start) begin
      cap1[ns1 % 2048] <= u1.tx_byte;
      gap1[ns1 % 2048] <= gapc1;
      ns1   <= ns1 + 1;
      gapc1 <= 0;
    end else if (dn1) gapc1 <= 0;
    else gapc1 <= gapc1 + 1;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input int sel, input logic [7:0] a, input logic [7:0] m, input logic [15:0] d);
    @(negedge clk);
    addr = a; mode = m; data = d;
    if (sel == 0) dr0 = 1'b1; else dr1 = 1'b1;
    #1 chk("tc_drop_on_accept", (sel == 0) ? tc0 : tc1, 0);
    @(negedge clk);
    dr0 = 1'b0; dr1 = 1'b0;
  endtask

  task automatic wait_idle(input int sel);
    int k;
    k = 0;
    while ((((sel == 0) ? tc0 : tc1) !== 1'b1) && k < 300) begin
      @(negedge clk); k++;
    end
    chk("idle_timeout", (k < 300), 1);
  endtask

  task automatic wait_starts(input int sel, input int target);
    int k;
    k = 0;
    while ((((sel == 0) ? ns0 : ns1) < target) && k < 300) begin
      @(negedge clk); k++;
    end
    chk("start_timeout", (k < 300), 1);
  endtask

  task automatic chk_frame(input int sel, input int base, input logic [7:0] b1, input logic [7:0] b2,
                           input logic [7:0] b3, input logic [7:0] b4, input logic [7:0] b5,
                           input int gexp);
    logic [7:0] e [6];
    e = '{8'hA5, b1, b2, b3, b4, b5};
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("dut%0d_byte%0d", sel, i),
          (sel == 0) ? cap0[(base + i) % 2048] : cap1[(base + i) % 2048], e[i]);
      if (gexp >= 0 && i > 0)
        chk($sformatf("dut%0d_gap%0d", sel, i),
            (sel == 0) ? gap0[(base + i) % 2048] : gap1[(base + i) % 2048], gexp);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    int b6;
    reset = 1'b0; dr0 = 1'b0; dr1 = 1'b0; addr = '0; mode = '0; data = '0;
    rdy0 = 1'b1; rdy1 = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_tx_complete", tc0, 1);
    chk("rst_tx_byte", u0.tx_byte, 0);
    chk("rst_tx_start", u0.tx_start, 0);
    chk("rst_frame_count", fc0, 0);
    chk("rst_overrun", ov0, 0);
    @(negedge clk);
    reset = 1'b1;

    // Basic frame, earliest start one cycle after data_ready
    b = ns0;
    send(0, 8'h48, 8'h01, 16'h1234);
    chk("first_start_latency", u0.tx_start, 1);
    chk("first_byte_sync", u0.tx_byte, 8'hA5);
    wait_idle(0);
    chk_frame(0, b, 8'h48, 8'h01, 8'h12, 8'h34, 8'h6F, 0);
    chk("t1_frame_count", fc0, 1);

    // Stall with uart_ready low
    b = ns0;
    send(0, 8'h10, 8'h22, 16'hBEEF);
    wait_starts(0, b + 2);
    rdy0 = 1'b0;
    repeat (20) @(negedge clk);
    chk("stall_no_start", ns0, b + 2);
    chk("stall_byte_held", u0.tx_byte, 8'h22);
    chk("stall_start_low", u0.tx_start, 0);
    rdy0 = 1'b1;
    wait_idle(0);
    chk_frame(0, b, 8'h10, 8'h22, 8'hBE, 8'hEF, 8'h63, -1);
    chk("t2_frame_count", fc0, 2);

    // Three idle cycles between done and next start
    b = ns1;
    send(1, 8'h48, 8'h01, 16'h1234);
    wait_idle(1);
    chk_frame(1, b, 8'h48, 8'h01, 8'h12, 8'h34, 8'h6F, 3);
    chk("t3_frame_count", fc1, 1);

    // Overrun during byte 2
    b = ns0;
    send(0, 8'h01, 8'h02, 16'h0304);
    wait_starts(0, b + 3);
    @(negedge clk);
    addr = 8'hFF; mode = 8'hEE; data = 16'hDDCC; dr0 = 1'b1;
    #1 chk("ovr_tc_low", tc0, 0);
    @(negedge clk);
    dr0 = 1'b0;
    chk("ovr_set", ov0, 1);
    chk("ovr_tc_still_low", tc0, 0);
    wait_idle(0);
    chk_frame(0, b, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04, 0);
    chk("ovr_sticky_end", ov0, 1);
    chk("t4_frame_count", fc0, 3);

    // Reset while waiting for byte 3 done
    b = ns0;
    send(0, 8'h55, 8'h66, 16'h7788);
    wait_starts(0, b + 4);
    repeat (3) @(negedge clk);
    chk("ovr_sticky_next", ov0, 1);
    reset = 1'b0;
    #1;
    chk("mid_rst_tx_byte", u0.tx_byte, 0);
    chk("mid_rst_tx_start", u0.tx_start, 0);
    chk("mid_rst_frame_count", fc0, 0);
    chk("mid_rst_overrun", ov0, 0);
    chk("mid_rst_tx_complete", tc0, 1);
    @(negedge clk);
    reset = 1'b1;
    repeat (40) @(negedge clk);
    chk("post_rst_no_start", ns0, b + 4);
    chk("post_rst_idle", tc0, 1);

    // 256 frames back-to-back, frame_count wraps
    b6 = ns0;
    for (int i = 0; i < 256; i++) begin
      wait_idle(0);
      if (i == 255) chk("fc_before_wrap", fc0, 255);
      b = ns0;
      send(0, 8'(i), ~8'(i), {8'(i), 8'(i)});
    end
    wait_idle(0);
    chk("fc_wrapped", fc0, 0);
    chk("last_checksum", cap0[(b + 5) % 2048], 8'hFF);
    chk("bytes_256_frames", ns0 - b6, 1536);
    chk("dut0_start_rules", bad0, 0);
    chk("dut1_start_rules", bad1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
